normalise_round64: RTL and testbench

- Post-add normalise and round stage for the 64-bit floating-point adder datapath.
- Sits directly downstream of the 53-bit significand adder stage.
- Consumes the raw sum (sign, carry-out, 53-bit significand, guard/round/sticky, pre-normalisation exponent).
- Multi-cycle FSM: renormalises by iterative single-bit shifts, rounds to nearest-even, detects overflow/underflow, and packs an IEEE-754 double under a valid/ready handshake.

---
 rtl/normalise_round64.sv | 183 ++++++++++++++++++
 tb/tb_normalise_round64.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/normalise_round64.sv
// Post-add normalise/round stage: renormalises the adder sum one bit per cycle, rounds to
// nearest-even, detects overflow/underflow and packs an IEEE-754 double.
// Latency: 2 edges (special/zero), 3 (normalised/carry-out), k+4 (k left shifts).
// Backpressure: accepts only in IDLE; the result is held in DONE until out_ready.
// Ports: clk/rst (async active-low), in_valid/in_ready input handshake, sign_in, cout_in,
//        exp_in, mant_in, grs_in, nan_in, inf_in sum operand; out_valid/out_ready output
//        handshake, result {sign,exp,frac}, overflow/underflow/inexact flags.
module normalise_round64 #(
    parameter int EXP_W  = 11,
    parameter int FRAC_W = 52,
    parameter bit FTZ    = 1'b1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic                    sign_in,
    input  logic                    cout_in,
    input  logic [EXP_W-1:0]        exp_in,
    input  logic [FRAC_W:0]         mant_in,
    input  logic [2:0]              grs_in,
    input  logic                    nan_in,
    input  logic                    inf_in,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [EXP_W+FRAC_W:0]   result,
    output logic                    overflow,
    output logic                    underflow,
    output logic                    inexact
);

    // One extra exponent bit so +1 past the max and the underflow test never wrap.
    localparam int EW = EXP_W + 1;
    localparam logic [EW-1:0] EXP_MAX = {1'b0, {EXP_W{1'b1}}};

    typedef enum logic [2:0] {IDLE, CHECK, SHIFT, ROUND, DONE} state_t;

    state_t                 state_q;
    logic                   sign_q, cout_q, nan_q, inf_q;
    logic [EW-1:0]          exp_q;
    logic [FRAC_W:0]        mant_q;
    logic                   g_q, r_q, s_q;
    logic [EXP_W+FRAC_W:0]  result_q;
    logic                   out_valid_q, overflow_q, underflow_q, inexact_q;

    // Rounding datapath, evaluated from the registered significand while in ROUND.
    logic                   inc_d;
    logic [FRAC_W+1:0]      sum_d;
    logic [FRAC_W-1:0]      rnd_frac_d;
    logic [EW-1:0]          rnd_exp_d;

    always_comb begin
        inc_d      = g_q & (r_q | s_q | mant_q[0]);
        sum_d      = {1'b0, mant_q} + (FRAC_W+2)'(inc_d);
        rnd_frac_d = sum_d[FRAC_W-1:0];
        rnd_exp_d  = exp_q;
        if (sum_d[FRAC_W+1]) begin
            rnd_frac_d = sum_d[FRAC_W:1];
            rnd_exp_d  = exp_q + EW'(1);
        end else if ((exp_q == '0) && sum_d[FRAC_W]) begin
            // Subnormal rounded up into the smallest normal.
            rnd_exp_d = EW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            sign_q      <= 1'b0;
            cout_q      <= 1'b0;
            nan_q       <= 1'b0;
            inf_q       <= 1'b0;
            exp_q       <= '0;
            mant_q      <= '0;
            g_q         <= 1'b0;
            r_q         <= 1'b0;
            s_q         <= 1'b0;
            result_q    <= '0;
            out_valid_q <= 1'b0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
            inexact_q   <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (in_valid) begin
                        sign_q      <= sign_in;
                        cout_q      <= cout_in;
                        nan_q       <= nan_in;
                        inf_q       <= inf_in;
                        exp_q       <= {1'b0, exp_in};
                        mant_q      <= mant_in;
                        g_q         <= grs_in[2];
                        r_q         <= grs_in[1];
                        s_q         <= grs_in[0];
                        overflow_q  <= 1'b0;
                        underflow_q <= 1'b0;
                        inexact_q   <= 1'b0;
                        state_q     <= CHECK;
                    end
                end
                CHECK: begin
                    if (nan_q) begin
                        result_q    <= {1'b0, {EXP_W{1'b1}}, 1'b1, {(FRAC_W-1){1'b0}}};
                        out_valid_q <= 1'b1;
                        state_q     <= DONE;
                    end else if (inf_q) begin
                        result_q    <= {sign_q, {EXP_W{1'b1}}, {FRAC_W{1'b0}}};
                        out_valid_q <= 1'b1;
                        state_q     <= DONE;
                    end else if (cout_q) begin
                        // Carry-out: fold the carry back in and push one bit into G/R/S.
                        mant_q  <= {1'b1, mant_q[FRAC_W:1]};
                        g_q     <= mant_q[0];
                        r_q     <= g_q;
                        s_q     <= r_q | s_q;
                        exp_q   <= exp_q + EW'(1);
                        state_q <= ROUND;
                    end else if ((mant_q == '0) && !g_q && !r_q && !s_q) begin
                        result_q    <= {sign_q, {(EXP_W+FRAC_W){1'b0}}};
                        out_valid_q <= 1'b1;
                        state_q     <= DONE;
                    end else if (mant_q[FRAC_W]) begin
                        state_q <= ROUND;
                    end else begin
                        state_q <= SHIFT;
                    end
                end
                SHIFT: begin
                    if (mant_q[FRAC_W]) begin
                        state_q <= ROUND;
                    end else if (exp_q <= EW'(1)) begin
                        underflow_q <= 1'b1;
                        if (FTZ) begin
                            result_q    <= {sign_q, {(EXP_W+FRAC_W){1'b0}}};
                            inexact_q   <= 1'b1;
                            out_valid_q <= 1'b1;
                            state_q     <= DONE;
                        end else begin
                            // Exponent 0 marks a subnormal for the rounding step.
                            exp_q   <= '0;
                            state_q <= ROUND;
                        end
                    end else begin
                        // R is consumed into G and refilled with zero; S stays sticky.
                        mant_q  <= {mant_q[FRAC_W-1:0], g_q};
                        g_q     <= r_q;
                        r_q     <= 1'b0;
                        exp_q   <= exp_q - EW'(1);
                        state_q <= SHIFT;
                    end
                end
                ROUND: begin
                    if (rnd_exp_d >= EXP_MAX) begin
                        result_q   <= {sign_q, {EXP_W{1'b1}}, {FRAC_W{1'b0}}};
                        overflow_q <= 1'b1;
                        inexact_q  <= 1'b1;
                    end else begin
                        result_q  <= {sign_q, rnd_exp_d[EXP_W-1:0], rnd_frac_d};
                        inexact_q <= g_q | r_q | s_q;
                    end
                    out_valid_q <= 1'b1;
                    state_q     <= DONE;
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid_q <= 1'b0;
                        state_q     <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = out_valid_q;
    assign result    = result_q;
    assign overflow  = overflow_q;
    assign underflow = underflow_q;
    assign inexact   = inexact_q;

endmodule

// File: tb/tb_normalise_round64.sv
module tb_normalise_round64;

    localparam bit FTZ = 1'b1;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic        sign_in = 1'b0;
    logic        cout_in = 1'b0;
    logic [10:0] exp_in = '0;
    logic [52:0] mant_in = '0;
    logic [2:0]  grs_in = '0;
    logic        nan_in = 1'b0;
    logic        inf_in = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [63:0] result;
    logic        overflow, underflow, inexact;

    int checks = 0;
    int failures = 0;

    normalise_round64 #(.EXP_W(11), .FRAC_W(52), .FTZ(FTZ)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .sign_in(sign_in), .cout_in(cout_in), .exp_in(exp_in), .mant_in(mant_in),
        .grs_in(grs_in), .nan_in(nan_in), .inf_in(inf_in),
        .out_valid(out_valid), .out_ready(out_ready),
        .result(result), .overflow(overflow), .underflow(underflow), .inexact(inexact)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Reference: treats {mant,G,R} as one fixed-point value with S as a sticky bit,
    // normalises it by left shifts bounded by the exponent, then rounds to nearest-even.
    task automatic model(input logic s, input logic c, input logic [10:0] e_in,
                         input logic [52:0] m_in, input logic [2:0] grs,
                         input logic n, input logic i,
                         output logic [63:0] res, output logic [2:0] flg, output int lat);
        logic [54:0] v;
        logic [53:0] m;
        logic        g, r, st;
        int          e, k;
        bit          uf, need_round;
        flg = 3'b000; need_round = 0; uf = 0; k = 0;
        m = '0; g = 0; r = 0; st = 0; e = 0; res = '0; lat = 0;
        if (n) begin
            res = 64'h7FF8000000000000; lat = 2;
        end else if (i) begin
            res = {s, 11'h7FF, 52'h0}; lat = 2;
        end else if (c) begin
            m = {1'b0, 1'b1, m_in[52:1]}; g = m_in[0]; r = grs[2]; st = grs[1] | grs[0];
            e = int'(e_in) + 1; lat = 3; need_round = 1;
        end else if (m_in == '0 && grs == 3'b000) begin
            res = {s, 63'h0}; lat = 2;
        end else begin
            v = {m_in, grs[2:1]}; st = grs[0]; e = int'(e_in);
            if (v[54]) lat = 3;
            else begin
                while (!v[54] && !uf) begin
                    if (e <= 1) uf = 1;
                    else begin v = v << 1; e--; k++; end
                end
                lat = (uf && FTZ) ? k + 3 : k + 4;
            end
            if (uf && FTZ) begin
                res = {s, 63'h0}; flg = 3'b011;
            end else begin
                if (uf) begin e = 0; flg[1] = 1'b1; end
                m = {1'b0, v[54:2]}; g = v[1]; r = v[0]; need_round = 1;
            end
        end
        if (need_round) begin
            flg[0] = g | r | st;
            if (g && (r || st || m[0])) m = m + 54'd1;
            if (m[53]) begin m = m >> 1; e++; end
            else if (e == 0 && m[52]) e = 1;
            if (e >= 2047) begin
                res = {s, 11'h7FF, 52'h0}; flg[2] = 1'b1; flg[0] = 1'b1;
            end else begin
                res = {s, e[10:0], m[51:0]};
            end
        end
    endtask

    task automatic do_op(input logic s, input logic c, input logic [10:0] e,
                         input logic [52:0] m, input logic [2:0] grs,
                         input logic n, input logic i, input int hold, input string tag,
                         output logic [63:0] res_obs, output int lat_obs);
        logic [63:0] exp_res;
        logic [2:0]  exp_flg;
        int          exp_lat;
        model(s, c, e, m, grs, n, i, exp_res, exp_flg, exp_lat);
        @(negedge clk);
        sign_in = s; cout_in = c; exp_in = e; mant_in = m; grs_in = grs;
        nan_in = n; inf_in = i; in_valid = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
        lat_obs = 1;
        while (!out_valid && lat_obs < 300) begin
            @(posedge clk);
            #1 lat_obs++;
        end
        chk({tag, "_lat"}, 64'(lat_obs), 64'(exp_lat));
        chk({tag, "_res"}, result, exp_res);
        chk({tag, "_flags"}, {61'h0, overflow, underflow, inexact}, {61'h0, exp_flg});
        res_obs = result;
        for (int h = 0; h < hold; h++) begin
            @(posedge clk);
            #1;
            chk({tag, "_hold_vld"}, {63'h0, out_valid}, 64'h1);
            chk({tag, "_hold_rdy"}, {63'h0, in_ready}, 64'h0);
            chk({tag, "_hold_res"}, result, exp_res);
        end
        @(negedge clk);
        chk({tag, "_no_accept"}, {63'h0, in_ready}, 64'h0);
        out_ready = 1'b1;
        @(posedge clk);
        #1 out_ready = 1'b0;
        chk({tag, "_consumed"}, {62'h0, out_valid, in_ready}, 64'h1);
    endtask

    initial begin
        logic [63:0] r;
        logic [63:0] rnd;
        logic [52:0] m;
        int          lat;

        // Reset state
        #12;
        chk("rst_outputs", {result[63:0]}, 64'h0);
        chk("rst_ctrl", {60'h0, out_valid, overflow, underflow, inexact}, 64'h0);
        @(negedge clk);
        rst = 1'b1;
        #1 chk("rst_in_ready", {63'h0, in_ready}, 64'h1);

        do_op(0, 0, 11'h3FF, 53'h10000000000000, 3'b000, 0, 0, 0, "one", r, lat);
        chk("one_const", r, 64'h3FF0000000000000);
        chk("one_lat_const", 64'(lat), 64'd3);
        do_op(0, 1, 11'h3FF, 53'h10000000000000, 3'b000, 0, 0, 0, "cout", r, lat);
        chk("cout_const", r, 64'h4008000000000000);
        do_op(0, 0, 11'h3FF, 53'h1FFFFFFFFFFFFF, 3'b100, 0, 0, 0, "rnd_carry", r, lat);
        chk("rnd_carry_const", r, 64'h4000000000000000);
        do_op(0, 0, 11'h3FF, 53'h10000000000000, 3'b100, 0, 0, 0, "tie_even", r, lat);
        chk("tie_even_const", r, 64'h3FF0000000000000);
        do_op(0, 0, 11'h3FF, 53'h1, 3'b000, 0, 0, 0, "deep", r, lat);
        chk("deep_const", r, 64'h3CB0000000000000);
        chk("deep_lat_const", 64'(lat), 64'd56);
        do_op(1, 1, 11'h7FE, 53'h0, 3'b000, 0, 0, 0, "ovf", r, lat);
        chk("ovf_const", r, 64'hFFF0000000000000);
        do_op(0, 0, 11'h001, 53'h08000000000000, 3'b000, 0, 0, 0, "ftz", r, lat);
        chk("ftz_const", r, 64'h0);
        do_op(1, 0, 11'h123, 53'h0, 3'b000, 1, 0, 0, "nan", r, lat);
        chk("nan_const", r, 64'h7FF8000000000000);
        do_op(1, 0, 11'h123, 53'h0, 3'b000, 0, 1, 10, "inf_hold", r, lat);
        do_op(1, 0, 11'h200, 53'h0, 3'b000, 0, 0, 0, "zero", r, lat);
        do_op(0, 0, 11'h400, 53'h10000000000001, 3'b010, 0, 0, 0, "below_half", r, lat);

        // Reset pulsed while the deep-shift operand is in SHIFT (previous result nonzero)
        @(negedge clk);
        sign_in = 0; cout_in = 0; exp_in = 11'h3FF; mant_in = 53'h1; grs_in = 3'b000;
        nan_in = 0; inf_in = 0; in_valid = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
        repeat (10) @(posedge clk);
        #2 rst = 1'b0;
        #1;
        chk("midrst_res", result, 64'h0);
        chk("midrst_ctrl", {60'h0, out_valid, overflow, underflow, inexact}, 64'h0);
        @(negedge clk);
        rst = 1'b1;
        #1 chk("midrst_in_ready", {63'h0, in_ready}, 64'h1);
        repeat (3) @(posedge clk);
        #1 chk("midrst_idle", {63'h0, out_valid}, 64'h0);
        do_op(0, 0, 11'h3FF, 53'h10000000000000, 3'b000, 0, 0, 0, "after_rst", r, lat);

        // Randomised operands against the reference
        for (int t = 0; t < 120; t++) begin
            rnd = {$urandom, $urandom};
            m = rnd[52:0] >> $urandom_range(0, 53);
            do_op(1'($urandom_range(0, 1)), ($urandom_range(0, 3) == 0),
                  ($urandom_range(0, 7) == 0) ? 11'($urandom_range(0, 60))
                                               : 11'($urandom_range(1, 2046)),
                  m, 3'($urandom_range(0, 7)),
                  ($urandom_range(0, 19) == 0), ($urandom_range(0, 19) == 0),
                  0, "rand", r, lat);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
